// File: rtl/hpi_seq_pkg.sv
// +-----------------------------------------------------------------------+
// | hpi_seq_pkg: shared types and default timing for hpi_bus_sequencer    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package hpi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4,
        ST_CHIPRST = 3'd5
    } hpi_state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  addr;
        logic [15:0] wdata;
    } hpi_req_t;

    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_STROBE_CYC  = 3;
    localparam int DEF_HOLD_CYC    = 1;
    localparam int DEF_RECOVER_CYC = 1;
    localparam int DEF_RESET_CYC   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hpi_bus_sequencer_if.sv
// +-----------------------------------------------------------------------+
// | hpi_bus_sequencer_if: requester handshake plus HPI pin bundle         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface hpi_bus_sequencer_if;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_write;
    logic [1:0][1:0]   req_addr;
    logic [1:0][15:0]  req_wdata;
    logic              rsp_valid;
    logic              rsp_port;
    logic [15:0]       rsp_rdata;
    logic              chip_rst_req;
    logic              busy;
    logic [1:0]        hpi_addr;
    logic              hpi_cs_n;
    logic              hpi_r_n;
    logic              hpi_w_n;
    logic              hpi_reset_n;
    logic [15:0]       hpi_data_out;
    logic              hpi_data_oe;
    logic [15:0]       hpi_data_in;

    // The master side also stands in for the board, so it sources hpi_data_in.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, chip_rst_req, hpi_data_in,
        input  req_ready, rsp_valid, rsp_port, rsp_rdata, busy,
        input  hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n, hpi_data_out, hpi_data_oe
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, chip_rst_req, hpi_data_in,
        output req_ready, rsp_valid, rsp_port, rsp_rdata, busy,
        output hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n, hpi_data_out, hpi_data_oe
    );

endinterface

`default_nettype wire

// File: rtl/hpi_rr_arbiter.sv
// +-----------------------------------------------------------------------+
// | hpi_rr_arbiter: two-port round-robin pick, favouring the port that    |
// | was not granted last when both request. Rev 1.0                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module hpi_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |valid;
        grant_idx   = 1'b0;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hpi_bus_sequencer.sv
// +-----------------------------------------------------------------------+
// | hpi_bus_sequencer: arbitrates two HPI masters and stretches each      |
// | access to programmable setup/strobe/hold/recovery; issues chip reset. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module hpi_bus_sequencer
    import hpi_seq_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int STROBE_CYC  = DEF_STROBE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC,
    parameter int RESET_CYC   = DEF_RESET_CYC
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    hpi_bus_sequencer_if.slave bus
);

    localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, STROBE_CYC),
                                             max_int(HOLD_CYC, RECOVER_CYC)), RESET_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    hpi_state_e  state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    hpi_req_t    req_q, req_d;
    logic        port_q, port_d;
    logic        last_q, last_d;
    logic        flag_q, flag_d;
    logic        grant_valid, grant_idx, accept, active_d;

    logic        cs_n_q, cs_n_d, r_n_q, r_n_d, w_n_q, w_n_d;
    logic        chip_rst_n_q, chip_rst_n_d, oe_q, oe_d, busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_port_q, rsp_port_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] dout_q, dout_d, rdata_q, rdata_d;

    hpi_rr_arbiter u_arb (
        .valid       (bus.req_valid),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin : p_fsm
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        port_d      = port_q;
        last_d      = last_q;
        rsp_valid_d = 1'b0;
        rsp_port_d  = rsp_port_q;
        rdata_d     = rdata_q;
        accept      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flag_q) begin
                    state_d = ST_CHIPRST;
                    cnt_d   = cnt_t'(RESET_CYC - 1);
                end else if (grant_valid) begin
                    accept      = 1'b1;
                    state_d     = ST_SETUP;
                    cnt_d       = cnt_t'(SETUP_CYC - 1);
                    port_d      = grant_idx;
                    last_d      = grant_idx;
                    req_d.write = bus.req_write[grant_idx];
                    req_d.addr  = bus.req_addr[grant_idx];
                    req_d.wdata = bus.req_wdata[grant_idx];
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = cnt_t'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_HOLD;
                    cnt_d       = cnt_t'(HOLD_CYC - 1);
                    rsp_valid_d = 1'b1;
                    rsp_port_d  = port_q;
                    rdata_d     = req_q.write ? 16'h0000 : bus.hpi_data_in;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECOVER;
                    cnt_d   = cnt_t'(RECOVER_CYC - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_RECOVER: begin
                // A pending chip reset goes straight out of recovery so the
                // reset pulse starts without an idle gap.
                if (cnt_q == '0) begin
                    if (flag_q) begin
                        state_d = ST_CHIPRST;
                        cnt_d   = cnt_t'(RESET_CYC - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_CHIPRST: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests arriving while a reset is starting or running merge into it.
        if ((state_q == ST_CHIPRST) || (state_d == ST_CHIPRST)) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q | bus.chip_rst_req;
        end

        // Pin values are derived from the next state so they can be registered.
        active_d     = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d       = ~active_d;
        r_n_d        = ~((state_d == ST_STROBE) && !req_d.write);
        w_n_d        = ~((state_d == ST_STROBE) && req_d.write);
        oe_d         = active_d && req_d.write;
        addr_d       = active_d ? req_d.addr : addr_q;
        dout_d       = (active_d && req_d.write) ? req_d.wdata : dout_q;
        chip_rst_n_d = (state_d != ST_CHIPRST);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            port_q       <= 1'b0;
            last_q       <= 1'b1;
            flag_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            r_n_q        <= 1'b1;
            w_n_q        <= 1'b1;
            chip_rst_n_q <= 1'b1;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_port_q   <= 1'b0;
            addr_q       <= 2'b00;
            dout_q       <= 16'h0000;
            rdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            port_q       <= port_d;
            last_q       <= last_d;
            flag_q       <= flag_d;
            cs_n_q       <= cs_n_d;
            r_n_q        <= r_n_d;
            w_n_q        <= w_n_d;
            chip_rst_n_q <= chip_rst_n_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_port_q   <= rsp_port_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.req_ready    = (accept && reset_reset_n) ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_port     = rsp_port_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.busy         = busy_q;
    assign bus.hpi_addr     = addr_q;
    assign bus.hpi_cs_n     = cs_n_q;
    assign bus.hpi_r_n      = r_n_q;
    assign bus.hpi_w_n      = w_n_q;
    assign bus.hpi_reset_n  = chip_rst_n_q;
    assign bus.hpi_data_out = dout_q;
    assign bus.hpi_data_oe  = oe_q;

endmodule

`default_nettype wire

// File: tb/tb_hpi_bus_sequencer.sv
// +-----------------------------------------------------------------------+
// | tb_hpi_bus_sequencer: directed checks of arbitration, access timing,  |
// | chip reset and async reset behaviour. Rev 1.0                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_hpi_bus_sequencer;

    localparam int B_CS   = 0;
    localparam int B_RN   = 1;
    localparam int B_WN   = 2;
    localparam int B_OE   = 3;
    localparam int B_RSP  = 4;
    localparam int B_RSTN = 5;
    localparam int B_BUSY = 6;
    localparam int HMAX   = 4096;

    typedef struct packed { int cyc; logic port; } acc_t;
    typedef struct packed { int cyc; logic port; logic [15:0] data; } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [6:0]  fl1 [0:HMAX-1];
    logic [6:0]  fl2 [0:HMAX-1];
    logic [1:0]  ad1 [0:HMAX-1];
    logic [15:0] do1 [0:HMAX-1];
    acc_t acc1[$];
    acc_t acc2[$];
    rsp_t rsp1[$];
    rsp_t rsp2[$];

    hpi_bus_sequencer_if bus ();
    hpi_bus_sequencer_if bus2 ();

    hpi_bus_sequencer u_dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    hpi_bus_sequencer #(
        .SETUP_CYC   (2),
        .STROBE_CYC  (5),
        .HOLD_CYC    (3),
        .RECOVER_CYC (2),
        .RESET_CYC   (16)
    ) u_dut2 (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accepts are logged at the edge that takes them, tagged with the cycle index.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (bus.req_valid[p] && bus.req_ready[p])
                    acc1.push_back('{cyc: cyc, port: p[0]});
                if (bus2.req_valid[p] && bus2.req_ready[p])
                    acc2.push_back('{cyc: cyc, port: p[0]});
            end
        end
    end

    always @(negedge clk) begin
        if (cyc < HMAX) begin
            fl1[cyc] = {bus.busy, bus.hpi_reset_n, bus.rsp_valid, bus.hpi_data_oe,
                        bus.hpi_w_n, bus.hpi_r_n, bus.hpi_cs_n};
            fl2[cyc] = {bus2.busy, bus2.hpi_reset_n, bus2.rsp_valid, bus2.hpi_data_oe,
                        bus2.hpi_w_n, bus2.hpi_r_n, bus2.hpi_cs_n};
            ad1[cyc] = bus.hpi_addr;
            do1[cyc] = bus.hpi_data_out;
        end
        if (bus.rsp_valid)
            rsp1.push_back('{cyc: cyc, port: bus.rsp_port, data: bus.rsp_rdata});
        if (bus2.rsp_valid)
            rsp2.push_back('{cyc: cyc, port: bus2.rsp_port, data: bus2.rsp_rdata});
    end

    function automatic logic [31:0] win(input bit d2, input int base, input int b, input int len);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < len; i++)
            v[i] = d2 ? fl2[base+i][b] : fl1[base+i][b];
        return v;
    endfunction

    function automatic acc_t acc_get(input bit d2, input int i);
        acc_t r;
        r.cyc  = -1000;
        r.port = 1'b0;
        if (!d2 && i < acc1.size()) r = acc1[i];
        if (d2 && i < acc2.size())  r = acc2[i];
        return r;
    endfunction

    function automatic rsp_t rsp_get(input bit d2, input int i);
        rsp_t r;
        r.cyc  = -1000;
        r.port = 1'b0;
        r.data = 16'hDEAD;
        if (!d2 && i < rsp1.size()) r = rsp1[i];
        if (d2 && i < rsp2.size())  r = rsp2[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        acc1.delete();
        acc2.delete();
        rsp1.delete();
        rsp2.delete();
    endtask

    initial begin
        int   a;
        acc_t ac;
        rsp_t rs;

        bus.req_valid     = 2'b11;
        bus.req_write     = 2'b00;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.chip_rst_req  = 1'b0;
        bus.hpi_data_in   = 16'h0000;
        bus2.req_valid    = 2'b00;
        bus2.req_write    = 2'b00;
        bus2.req_addr     = '0;
        bus2.req_wdata    = '0;
        bus2.chip_rst_req = 1'b0;
        bus2.hpi_data_in  = 16'h0000;

        // Reset values, with both requests asserted to prove ready stays low
        step(2);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_strobes", 32'({bus.hpi_cs_n, bus.hpi_r_n, bus.hpi_w_n, bus.hpi_reset_n}), 32'hF);
        check("rst_oe_busy_rsp", 32'({bus.hpi_data_oe, bus.busy, bus.rsp_valid, bus.rsp_port}), 32'h0);
        check("rst_addr_data", {bus.hpi_addr, bus.hpi_data_out, 14'h0}, 32'h0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        step(2);

        // Single write, port 0
        clear_logs();
        bus.req_valid    = 2'b01;
        bus.req_write    = 2'b01;
        bus.req_addr[0]  = 2'd2;
        bus.req_wdata[0] = 16'h1234;
        #1 check("wr_ready", 32'(bus.req_ready), 32'h1);
        step(1);
        bus.req_valid = 2'b00;
        step(8);
        check("wr_accepts", acc1.size(), 1);
        ac = acc_get(0, 0);
        a  = ac.cyc;
        check("wr_cs_n", win(0, a, B_CS, 8), 32'hC1);
        check("wr_w_n", win(0, a, B_WN, 8), 32'hE3);
        check("wr_r_n", win(0, a, B_RN, 8), 32'hFF);
        check("wr_oe", win(0, a, B_OE, 8), 32'h3E);
        check("wr_rsp_valid", win(0, a, B_RSP, 8), 32'h20);
        check("wr_addr", 32'(ad1[a+3]), 32'h2);
        check("wr_dout", 32'(do1[a+3]), 32'h1234);
        rs = rsp_get(0, 0);
        check("wr_rsp_cyc", rs.cyc - a, 5);
        check("wr_rsp_port_data", 32'({rs.port, rs.data}), 32'h0);

        // Single read, port 1; data changes across strobe, last value must win
        clear_logs();
        bus.req_valid   = 2'b10;
        bus.req_write   = 2'b00;
        bus.req_addr[1] = 2'd1;
        #1 check("rd_ready", 32'(bus.req_ready), 32'h2);
        step(1);
        bus.req_valid = 2'b00;
        step(1);
        bus.hpi_data_in = 16'h1111;
        step(1);
        bus.hpi_data_in = 16'h2222;
        step(1);
        bus.hpi_data_in = 16'hBEEF;
        step(1);
        bus.hpi_data_in = 16'h0000;
        step(4);
        ac = acc_get(0, 0);
        a  = ac.cyc;
        check("rd_accept_port", 32'(ac.port), 32'h1);
        check("rd_r_n", win(0, a, B_RN, 8), 32'hE3);
        check("rd_w_n", win(0, a, B_WN, 8), 32'hFF);
        check("rd_oe", win(0, a, B_OE, 8), 32'h00);
        check("rd_cs_n", win(0, a, B_CS, 8), 32'hC1);
        check("rd_addr", 32'(ad1[a+3]), 32'h1);
        rs = rsp_get(0, 0);
        check("rd_rsp_cyc", rs.cyc - a, 5);
        check("rd_rsp_port_data", 32'({rs.port, rs.data}), 32'h1BEEF);

        // Both ports valid continuously: alternating grants every 7 cycles
        clear_logs();
        bus.req_valid    = 2'b11;
        bus.req_write    = 2'b11;
        bus.req_addr[0]  = 2'd0;
        bus.req_addr[1]  = 2'd3;
        bus.req_wdata[0] = 16'hAAAA;
        bus.req_wdata[1] = 16'h5555;
        step(22);
        bus.req_valid = 2'b00;
        step(8);
        check("rr_accepts", acc1.size(), 4);
        ac = acc_get(0, 0);
        a  = ac.cyc;
        for (int k = 0; k < 4; k++) begin
            ac = acc_get(0, k);
            check($sformatf("rr_port%0d", k), 32'(ac.port), 32'(k % 2));
            check($sformatf("rr_cyc%0d", k), ac.cyc - a, 7 * k);
        end
        check("rr_rsps", rsp1.size(), 4);

        // Chip reset requested mid-write while port 1 waits
        clear_logs();
        bus.req_valid    = 2'b11;
        bus.req_write    = 2'b01;
        bus.req_addr[1]  = 2'd2;
        step(1);
        bus.req_valid = 2'b10;
        step(2);
        bus.chip_rst_req = 1'b1;
        step(1);
        bus.chip_rst_req = 1'b0;
        step(20);
        bus.req_valid = 2'b00;
        step(10);
        check("cr_accepts", acc1.size(), 2);
        ac = acc_get(0, 0);
        a  = ac.cyc;
        check("cr_first_port", 32'(ac.port), 32'h0);
        ac = acc_get(0, 1);
        check("cr_second_port", 32'(ac.port), 32'h1);
        check("cr_second_cyc", ac.cyc - a, 23);
        check("cr_reset_n", win(0, a + 5, B_RSTN, 20), 32'hC0003);
        check("cr_cs_n", win(0, a + 7, B_CS, 16), 32'hFFFF);
        check("cr_busy", win(0, a + 7, B_BUSY, 16), 32'hFFFF);
        rs = rsp_get(0, 0);
        check("cr_wr_rsp", rs.cyc - a, 5);

        // Async reset during STROBE of a read
        clear_logs();
        bus.req_valid   = 2'b01;
        bus.req_write   = 2'b00;
        bus.req_addr[0] = 2'd3;
        bus.hpi_data_in = 16'h7777;
        step(1);
        bus.req_valid = 2'b00;
        step(2);
        check("ar_in_strobe", 32'(bus.hpi_r_n), 32'h0);
        rst_n = 1'b0;
        #1;
        check("ar_pins_released",
              32'({bus.hpi_cs_n, bus.hpi_r_n, bus.hpi_w_n, bus.hpi_data_oe, bus.busy}), 32'h1C);
        step(2);
        rst_n = 1'b1;
        step(10);
        check("ar_no_rsp", rsp1.size(), 0);
        check("ar_one_accept", acc1.size(), 1);
        clear_logs();
        bus.req_valid    = 2'b10;
        bus.req_write    = 2'b10;
        bus.req_addr[1]  = 2'd3;
        bus.req_wdata[1] = 16'hA5A5;
        step(1);
        bus.req_valid = 2'b00;
        step(8);
        ac = acc_get(0, 0);
        a  = ac.cyc;
        check("ar_post_port", 32'(ac.port), 32'h1);
        check("ar_post_cs_n", win(0, a, B_CS, 8), 32'hC1);
        check("ar_post_w_n", win(0, a, B_WN, 8), 32'hE3);
        check("ar_post_addr_data", 32'({ad1[a+3], do1[a+3]}), 32'h3A5A5);
        rs = rsp_get(0, 0);
        check("ar_post_rsp_cyc", rs.cyc - a, 5);
        check("ar_post_rsp", 32'({rs.port, rs.data}), 32'h10000);

        // Stretched timing S=2,T=5,H=3,R=2 read, request held for back-to-back
        clear_logs();
        bus2.req_valid   = 2'b01;
        bus2.req_write   = 2'b00;
        bus2.req_addr[0] = 2'd2;
        bus2.hpi_data_in = 16'h5A5A;
        step(14);
        bus2.req_valid = 2'b00;
        step(16);
        check("p2_accepts", acc2.size(), 2);
        ac = acc_get(1, 0);
        a  = ac.cyc;
        check("p2_r_n", win(1, a, B_RN, 16), 32'hFF07);
        ac = acc_get(1, 1);
        check("p2_next_accept", ac.cyc - a, 13);
        rs = rsp_get(1, 0);
        check("p2_rsp_cyc", rs.cyc - a, 8);
        check("p2_rsp", 32'({rs.port, rs.data}), 32'h05A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hpi_bus_sequencer.md
# hpi_bus_sequencer

Sequences all bus cycles to the USB host controller's HPI port (2-bit address, 16-bit data, active-low chip-select/read/write/reset strobes). It shares the port between two requesters under round-robin arbitration and stretches every access to programmable setup/strobe/hold/recovery timing. It also generates the controller's hardware reset pulse. It sits between the SoC-side HPI masters (CPU bridge on port 0, USB keyboard poller on port 1) and the board-level HPI pins.

## Interface
- SETUP_CYC, 1: cycles address/CS (and write data) are valid before strobe; ≥1
- STROBE_CYC, 3: cycles R_n/W_n held low; ≥1
- HOLD_CYC, 1: cycles address/CS/data held after strobe release; ≥1
- RECOVER_CYC, 1: cycles CS_n high between accesses; ≥1
- RESET_CYC, 16: cycles hpi_reset_n held low per chip-reset request; ≥1
- clk_clk  in  1  single clock, all logic rising-edge
- reset_reset_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid (bit i = port i)
- req_ready  out  2  per-port accept; request taken when valid&ready
- req_write  in  2  per-port 1=write, 0=read
- req_addr  in  2x2  per-port HPI address
- req_wdata  in  2x16  per-port write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_port  out  1  port the completion belongs to
- rsp_rdata  out  16  read data (0 for writes)
- chip_rst_req  in  1  pulse: request an HPI chip reset
- busy  out  1  state ≠ IDLE
- hpi_addr  out  2; hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n  out  1 each
- hpi_data_out  out  16; hpi_data_oe  out  1 (tristate enable at top level); hpi_data_in  in  16

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RECOVER, CHIPRST. One down-counter, width $clog2(max param)+1, is loaded on every state entry.
- IDLE: if the reset flag is set, go to CHIPRST (priority over requests). Otherwise, if any req_valid is set, the arbiter picks a port: a single valid port wins; when both are valid, the port not granted last wins. req_ready is combinational, asserted only in IDLE with the reset flag clear, and only for the chosen port. On accept, latch write/addr/wdata/port and go to SETUP.
- SETUP (SETUP_CYC): hpi_cs_n=0, hpi_addr driven; for writes, hpi_data_oe=1 and hpi_data_out=wdata.
- STROBE (STROBE_CYC): additionally hpi_r_n=0 (read) or hpi_w_n=0 (write). Reads register hpi_data_in on the last STROBE cycle.
- HOLD (HOLD_CYC): strobes high; CS, address and data unchanged. rsp_valid=1 in the first HOLD cycle only.
- RECOVER (RECOVER_CYC): hpi_cs_n=1, hpi_data_oe=0, then IDLE.
- CHIPRST: hpi_reset_n=0 for RESET_CYC cycles, CS/R/W high, oe=0, then IDLE. The reset flag clears on entry.
- chip_rst_req sets a sticky flag in any state; a pulse during a transaction is serviced after RECOVER; a pulse during CHIPRST restarts nothing (merged).
- Last-grant register updates only on accept; its reset value is 1, so port 0 wins the first tie.

## Timing
- Reset values: req_ready=0 while in reset, rsp_valid=0, rsp_port=0, rsp_rdata=0, busy=0, hpi_cs_n=hpi_r_n=hpi_w_n=hpi_reset_n=1, hpi_addr=0, hpi_data_out=0, hpi_data_oe=0; state=IDLE, flag clear.
- With accept at cycle 0: SETUP occupies cycles 1..S, STROBE occupies S+1..S+T, rsp_valid at S+T+1, RECOVER at S+T+H+1. The next accept occurs no earlier than cycle S+T+H+R+1. Defaults: rsp at cycle 5, next accept at cycle 7.
- Async reset mid-access releases all strobes immediately; the in-flight request is dropped with no rsp.
- All HPI outputs are registered (glitch-free); only req_ready is combinational.

## Structure
- Package hpi_seq_pkg: state enum, request struct {write, addr[1:0], wdata[15:0]}, default timing constants.
- Sub-module hpi_rr_arbiter (2-port round-robin: valid[1:0], last, grant_valid, grant_idx) instantiated once; FSM/counter in the top.

## Test plan
- Single write, port 0, addr 2, data 0x1234 (defaults) -> cs_n low cycles 1-5, w_n low cycles 2-4, oe=1 cycles 1-5, rsp_valid at cycle 5 with port=0, rdata=0.
- Single read, port 1, addr 1, hpi_data_in=0xBEEF during strobe -> r_n low cycles 2-4, rsp_valid cycle 5 with port=1, rdata=0xBEEF, oe never high.
- Both ports valid continuously for 4 accesses -> grants 0,1,0,1; accepts at cycles 0,7,14,21.
- chip_rst_req pulse at cycle 3 of a port-0 write, port 1 valid -> write completes; hpi_reset_n low for 16 cycles from cycle 7; port 1 accepted after CHIPRST.
- reset_reset_n asserted in STROBE of a read -> strobes/cs_n high asynchronously; no rsp; the first post-reset request runs normally.
- Parameters S=2,T=5,H=3,R=2 read -> r_n low exactly 5 cycles, rsp at cycle 8, next accept at cycle 13.
